// File: rtl/ram_arbiter_pkg.sv
// +-----------------------------------------------------------------------+
// | ram_arbiter_pkg : shared defaults, requester IDs, read-tag record       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package ram_arbiter_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_arb_rr2.sv
// +-----------------------------------------------------------------------+
// | arb_rr2 : two-way round-robin selector with its own priority pointer  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module arb_rr2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // ptr_q = REQ_A means A wins a tie, REQ_B means B wins a tie
    req_id_e ptr_q;
    req_id_e ptr_d;

    always_comb begin
        gnt_o[0] = req_i[0] & (~req_i[1] | (ptr_q == REQ_A));
        gnt_o[1] = req_i[1] & (~req_i[0] | (ptr_q == REQ_B));
        ptr_d    = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = REQ_B;
        end else if (gnt_o[1]) begin
            ptr_d = REQ_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// +-----------------------------------------------------------------------+
// | ram_arbiter : two requesters sharing one synchronous single-port RAM  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic          a_gnt_o,
    output logic          a_rvalid_o,
    output logic [DW-1:0] a_rdata_o,

    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic          b_gnt_o,
    output logic          b_rvalid_o,
    output logic [DW-1:0] b_rdata_o,

    output logic          ram_ena_o,
    output logic          ram_wena_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
);

    logic [1:0]    sel;
    logic          a_gnt_q,  a_gnt_d;
    logic          b_gnt_q,  b_gnt_d;
    logic          ena_q,    ena_d;
    logic          wena_q,   wena_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] din_q,    din_d;
    rd_tag_t       tag_q,    tag_d;

    // A requester is ineligible in the cycle its grant is showing,
    // which makes a held request re-arbitrate as a fresh one.
    arb_rr2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({b_req_i & ~b_gnt_q, a_req_i & ~a_gnt_q}),
        .gnt_o (sel)
    );

    always_comb begin
        a_gnt_d = sel[0];
        b_gnt_d = sel[1];
        ena_d   = sel[0] | sel[1];
        wena_d  = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        if (sel[0]) begin
            wena_d = a_we_i;
            addr_d = a_addr_i;
            din_d  = a_wdata_i;
        end else if (sel[1]) begin
            wena_d = b_we_i;
            addr_d = b_addr_i;
            din_d  = b_wdata_i;
        end
        // The RAM performs the access on the edge that loads this tag,
        // so the tag and ram_dout line up in the following cycle.
        tag_d.valid = ena_q & ~wena_q;
        tag_d.id    = b_gnt_q ? REQ_B : REQ_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            ena_q   <= 1'b0;
            wena_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            tag_q   <= '{valid: 1'b0, id: REQ_A};
        end else begin
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            ena_q   <= ena_d;
            wena_q  <= wena_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            tag_q   <= tag_d;
        end
    end

    assign a_gnt_o    = a_gnt_q;
    assign b_gnt_o    = b_gnt_q;
    assign ram_ena_o  = ena_q;
    assign ram_wena_o = wena_q;
    assign ram_addr_o = addr_q;
    assign ram_din_o  = din_q;

    assign a_rvalid_o = tag_q.valid & (tag_q.id == REQ_A);
    assign b_rvalid_o = tag_q.valid & (tag_q.id == REQ_B);
    assign a_rdata_o  = a_rvalid_o ? ram_dout_i : '0;
    assign b_rdata_o  = b_rvalid_o ? ram_dout_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_ram_arbiter : directed self-checking bench with a behavioural RAM  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_ram_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_ena, ram_wena;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    logic [DW-1:0] mem [32];
    logic [31:0]   written = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_req_i    (a_req),
        .a_we_i     (a_we),
        .a_addr_i   (a_addr),
        .a_wdata_i  (a_wdata),
        .a_gnt_o    (a_gnt),
        .a_rvalid_o (a_rvalid),
        .a_rdata_o  (a_rdata),
        .b_req_i    (b_req),
        .b_we_i     (b_we),
        .b_addr_i   (b_addr),
        .b_wdata_i  (b_wdata),
        .b_gnt_o    (b_gnt),
        .b_rvalid_o (b_rvalid),
        .b_rdata_o  (b_rdata),
        .ram_ena_o  (ram_ena),
        .ram_wena_o (ram_wena),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hC0DE_0000 + a;
    endfunction

    // Synchronous RAM; unwritten words read back a known address pattern.
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wena) begin
                mem[ram_addr]     <= ram_din;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_dout <= written[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ena"},  ram_ena,  0);
        chk({tag, "_wena"}, ram_wena, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_din"},  ram_din,  0);
        chk({tag, "_agnt"}, a_gnt,    0);
        chk({tag, "_bgnt"}, b_gnt,    0);
        chk({tag, "_arv"},  a_rvalid, 0);
        chk({tag, "_brv"},  b_rvalid, 0);
        chk({tag, "_ard"},  a_rdata,  0);
        chk({tag, "_brd"},  b_rdata,  0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (2) tick();
        chk_all_zero("reset");

        // A writes FFFF_FFFF to addr 1
        rst_n = 1'b1;
        a_req = 1; a_we = 1; a_addr = 5'd1; a_wdata = 32'hFFFF_FFFF;
        tick();
        chk("wr_agnt", a_gnt, 1);
        chk("wr_bgnt", b_gnt, 0);
        chk("wr_ena",  ram_ena, 1);
        chk("wr_wena", ram_wena, 1);
        chk("wr_addr", ram_addr, 1);
        chk("wr_din",  ram_din, 32'hFFFF_FFFF);
        a_req = 0;
        tick();
        chk("wr_idle_agnt", a_gnt, 0);
        chk("wr_idle_ena",  ram_ena, 0);
        chk("wr_hold_addr", ram_addr, 1);
        chk("wr_hold_din",  ram_din, 32'hFFFF_FFFF);
        chk("wr_no_arv",    a_rvalid, 0);
        tick();
        chk("wr_no_arv2",   a_rvalid, 0);
        chk("wr_no_brv2",   b_rvalid, 0);

        // A reads addr 1
        a_req = 1; a_we = 0; a_addr = 5'd1;
        tick();
        chk("rd_agnt", a_gnt, 1);
        chk("rd_ena",  ram_ena, 1);
        chk("rd_wena", ram_wena, 0);
        chk("rd_arv_early", a_rvalid, 0);
        a_req = 0;
        tick();
        chk("rd_arv",   a_rvalid, 1);
        chk("rd_ard",   a_rdata, 32'hFFFF_FFFF);
        chk("rd_brv",   b_rvalid, 0);
        chk("rd_brd",   b_rdata, 0);
        tick();
        chk("rd_arv_end", a_rvalid, 0);
        chk("rd_ard_end", a_rdata, 0);

        // Fresh reset, then A writes 0 to addr 3 while B reads addr 3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1; a_we = 1; a_addr = 5'd3; a_wdata = 32'h0000_0000;
        b_req = 1; b_we = 0; b_addr = 5'd3;
        tick();
        chk("tie_agnt", a_gnt, 1);
        chk("tie_bgnt", b_gnt, 0);
        chk("tie_wena", ram_wena, 1);
        a_req = 0;
        tick();
        chk("tie_agnt2", a_gnt, 0);
        chk("tie_bgnt2", b_gnt, 1);
        chk("tie_wena2", ram_wena, 0);
        chk("tie_addr2", ram_addr, 3);
        b_req = 0;
        tick();
        chk("tie_brv", b_rvalid, 1);
        chk("tie_brd", b_rdata, 32'h0000_0000);
        chk("tie_arv", a_rvalid, 0);
        tick();

        // Both read continuously: A addr 4, B addr 7
        a_req = 1; a_we = 0; a_addr = 5'd4;
        b_req = 1; b_we = 0; b_addr = 5'd7;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_agnt", a_gnt, (i % 2 == 0));
            chk("rr_bgnt", b_gnt, (i % 2 == 1));
            chk("rr_ena",  ram_ena, 1);
            chk("rr_arv",  a_rvalid, (i % 2 == 1));
            chk("rr_brv",  b_rvalid, (i > 0 && i % 2 == 0));
            chk("rr_ard",  a_rdata, (i % 2 == 1) ? init_word(4) : 32'h0);
            chk("rr_brd",  b_rdata, (i > 0 && i % 2 == 0) ? init_word(7) : 32'h0);
        end
        a_req = 0; b_req = 0;
        tick();
        chk("rr_tail_ena", ram_ena, 0);
        chk("rr_tail_brv", b_rvalid, 1);
        chk("rr_tail_brd", b_rdata, init_word(7));
        tick();

        // B read granted, then reset the following cycle
        b_req = 1; b_we = 0; b_addr = 5'd7;
        tick();
        chk("rst_bgnt", b_gnt, 1);
        b_req = 0;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async");
        tick();
        chk("rst_hold_brv", b_rvalid, 0);
        rst_n = 1'b1;
        tick();
        chk("post_brv1", b_rvalid, 0);
        tick();
        chk("post_brv2", b_rvalid, 0);
        a_req = 1; a_we = 0; a_addr = 5'd4;
        b_req = 1; b_we = 0; b_addr = 5'd7;
        tick();
        chk("post_agnt", a_gnt, 1);
        chk("post_bgnt", b_gnt, 0);
        a_req = 0;
        tick();
        chk("post_bgnt2", b_gnt, 1);
        b_req = 0;
        tick();
        tick();

        // A alone holds a read of addr 2
        a_req = 1; a_we = 0; a_addr = 5'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("solo_agnt", a_gnt, (i % 2 == 0));
            chk("solo_ena",  ram_ena, (i % 2 == 0));
            chk("solo_bgnt", b_gnt, 0);
            chk("solo_arv",  a_rvalid, (i % 2 == 1));
            chk("solo_ard",  a_rdata, (i % 2 == 1) ? init_word(2) : 32'h0);
        end
        a_req = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
